// File: rtl/portal_indication_mux.sv
`default_nettype none
// ============================================================================
// Module : portal_indication_mux
// Brief  : Round-robin serialiser of one-deep indication buffers into a shared
//          word FIFO (header + payload words). PORTAL_INTR_MASK_EN adds intr_enable.
// Rev    : 1.0  initial release
// ============================================================================
module portal_indication_mux #(
  parameter int                        NUM_METHODS = 4,
  parameter int                        MAX_WORDS   = 4,
  parameter logic [16*NUM_METHODS-1:0] SIZE_TABLE  = {NUM_METHODS{16'd32}},
  parameter int                        DEPTH       = 16,
  parameter logic [31:0]               CHANNEL_ID  = 32'd0
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [NUM_METHODS*MAX_WORDS*32-1:0] ifc_enq_v,
  input  logic [NUM_METHODS-1:0]              EN_ifc_enq,
  output logic [NUM_METHODS-1:0]              RDY_ifc_enq,
  input  logic [15:0]                         messageSize_size_methodNumber,
  output logic [15:0]                         messageSize_size,
  output logic                                RDY_messageSize_size,
  output logic [31:0]                         ind_first,
  output logic                                RDY_ind_first,
  input  logic                                EN_ind_deq,
  output logic                                RDY_ind_deq,
  output logic                                ind_notEmpty,
  output logic                                RDY_ind_notEmpty,
`ifdef PORTAL_INTR_MASK_EN
  input  logic                                intr_enable,
`endif
  output logic                                intr_status,
  output logic                                RDY_intr_status,
  output logic [31:0]                         intr_channel,
  output logic                                RDY_intr_channel
);

  localparam int c_idx_w = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_msg_w = MAX_WORDS * 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [NUM_METHODS-1:0]   r_valid, w_valid_nxt, w_clr;
  logic [c_msg_w-1:0]       r_payload [NUM_METHODS];
  logic [c_idx_w-1:0]       r_grant, r_rr_last, w_pick;
  logic                     w_found;
  logic [4:0]               r_widx, w_cur_words;
  logic [5*NUM_METHODS-1:0] w_words;
  logic [31:0]              w_header, w_cur_word, w_push_data;
  logic                     w_push, w_pop, w_full, w_empty;
  logic [31:0]              r_mem [DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]       r_count;

  // Per-method payload word count (ceil of bits/32, clamped) and holding buffer
  for (genvar gi = 0; gi < NUM_METHODS; gi++) begin : g_method
    localparam int c_raw = (32'(SIZE_TABLE[16*gi +: 16]) + 31) / 32;
    assign w_words[5*gi +: 5] = 5'((c_raw > MAX_WORDS) ? MAX_WORDS : c_raw);

    always_ff @(posedge CLK) begin
      if (EN_ifc_enq[gi] && !r_valid[gi])
        r_payload[gi] <= ifc_enq_v[gi*c_msg_w +: c_msg_w];
    end
  end

  assign w_clr       = (r_state == ST_DONE) ? (NUM_METHODS'(1) << r_grant) : '0;
  assign w_valid_nxt = (r_valid | EN_ifc_enq) & ~w_clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_valid <= '0;
    else        r_valid <= w_valid_nxt;
  end

  // Search starts just after the last served method so every requester gets a turn
  always_comb begin : arb
    logic [NUM_METHODS-1:0] sh;
    int                     j;
    w_pick  = r_rr_last;
    w_found = 1'b0;
    sh      = '0;
    j       = 0;
    for (int k = 1; k <= NUM_METHODS; k++) begin
      j  = (32'(r_rr_last) + k) % NUM_METHODS;
      sh = r_valid >> j;
      if (!w_found && sh[0]) begin
        w_found = 1'b1;
        w_pick  = c_idx_w'(j);
      end
    end
  end

  assign w_cur_words = 5'(w_words >> (5 * 32'(r_grant)));
  assign w_cur_word  = 32'(r_payload[r_grant] >> (32 * 32'(r_widx)));
  assign w_header    = {16'(r_grant), 16'(w_cur_words) + 16'd1};

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = 32'd0;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_HDR;
      ST_HDR: begin
        w_push_data = w_header;
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = (w_cur_words == 5'd0) ? ST_DONE : ST_PAY;
        end
      end
      ST_PAY: begin
        w_push_data = w_cur_word;
        if (!w_full) begin
          w_push = 1'b1;
          if (r_widx == w_cur_words - 5'd1) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_grant   <= '0;
      r_rr_last <= c_idx_w'(NUM_METHODS - 1);
      r_widx    <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_found) r_grant <= w_pick;
        ST_HDR:  r_widx <= 5'd0;
        ST_PAY:  if (w_push) r_widx <= r_widx + 5'd1;
        ST_DONE: r_rr_last <= r_grant;
        default: ;
      endcase
    end
  end

  // Output FIFO: status from the registered count only, so no same-cycle bypass
  assign w_full  = (r_count == c_cnt_w'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = EN_ind_deq && !w_empty;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign RDY_ifc_enq          = ~r_valid;
  assign messageSize_size     = (32'(messageSize_size_methodNumber) < NUM_METHODS)
                              ? 16'(SIZE_TABLE >> (16 * 32'(messageSize_size_methodNumber)))
                              : 16'd0;
  assign RDY_messageSize_size = 1'b1;
  assign ind_notEmpty         = !w_empty;
  assign ind_first            = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign RDY_ind_first        = ind_notEmpty;
  assign RDY_ind_deq          = ind_notEmpty;
  assign RDY_ind_notEmpty     = 1'b1;
`ifdef PORTAL_INTR_MASK_EN
  assign intr_status          = ind_notEmpty & intr_enable;
`else
  assign intr_status          = ind_notEmpty;
`endif
  assign RDY_intr_status      = 1'b1;
  assign intr_channel         = CHANNEL_ID;
  assign RDY_intr_channel     = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_portal_indication_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_portal_indication_mux
// Brief  : Directed self-checking bench: default instance plus a 4-word instance
//          used to fill the FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module tb_portal_indication_mux;
  localparam int NM = 4;
  localparam int MW = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [NM*MW*32-1:0] ifc_enq_v, f_ifc_enq_v;
  logic [NM-1:0]       EN_ifc_enq, RDY_ifc_enq, f_EN_ifc_enq, f_RDY_ifc_enq;
  logic [15:0]         msz_num, msz, f_msz_num, f_msz;
  logic                rdy_msz, f_rdy_msz;
  logic [31:0]         ind_first, f_ind_first, intr_channel, f_intr_channel;
  logic                rdy_first, rdy_deq, EN_ind_deq, ind_notEmpty, rdy_ne;
  logic                f_rdy_first, f_rdy_deq, f_EN_ind_deq, f_ind_notEmpty, f_rdy_ne;
  logic                intr_status, rdy_is, rdy_ic, f_intr_status, f_rdy_is, f_rdy_ic;
`ifdef PORTAL_INTR_MASK_EN
  logic                intr_enable, f_intr_enable;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  portal_indication_mux dut (
    .CLK(CLK), .RST_N(RST_N),
    .ifc_enq_v(ifc_enq_v), .EN_ifc_enq(EN_ifc_enq), .RDY_ifc_enq(RDY_ifc_enq),
    .messageSize_size_methodNumber(msz_num), .messageSize_size(msz),
    .RDY_messageSize_size(rdy_msz),
    .ind_first(ind_first), .RDY_ind_first(rdy_first),
    .EN_ind_deq(EN_ind_deq), .RDY_ind_deq(rdy_deq),
    .ind_notEmpty(ind_notEmpty), .RDY_ind_notEmpty(rdy_ne),
`ifdef PORTAL_INTR_MASK_EN
    .intr_enable(intr_enable),
`endif
    .intr_status(intr_status), .RDY_intr_status(rdy_is),
    .intr_channel(intr_channel), .RDY_intr_channel(rdy_ic)
  );

  portal_indication_mux #(
    .NUM_METHODS(NM), .MAX_WORDS(MW), .SIZE_TABLE({NM{16'd128}}),
    .DEPTH(16), .CHANNEL_ID(32'h0000_0005)
  ) dut_full (
    .CLK(CLK), .RST_N(RST_N),
    .ifc_enq_v(f_ifc_enq_v), .EN_ifc_enq(f_EN_ifc_enq), .RDY_ifc_enq(f_RDY_ifc_enq),
    .messageSize_size_methodNumber(f_msz_num), .messageSize_size(f_msz),
    .RDY_messageSize_size(f_rdy_msz),
    .ind_first(f_ind_first), .RDY_ind_first(f_rdy_first),
    .EN_ind_deq(f_EN_ind_deq), .RDY_ind_deq(f_rdy_deq),
    .ind_notEmpty(f_ind_notEmpty), .RDY_ind_notEmpty(f_rdy_ne),
`ifdef PORTAL_INTR_MASK_EN
    .intr_enable(f_intr_enable),
`endif
    .intr_status(f_intr_status), .RDY_intr_status(f_rdy_is),
    .intr_channel(f_intr_channel), .RDY_intr_channel(f_rdy_ic)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    steps(2);
    RST_N = 1'b1;
    n_checks++;
    if (ind_notEmpty !== 1'b0 || RDY_ifc_enq !== 4'b1111 || ind_first !== 32'd0
        || intr_status !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ne=%b rdy=%b first=%h intr=%b, want ne=0 rdy=1111 first=0 intr=0",
               ind_notEmpty, RDY_ifc_enq, ind_first, intr_status);
    end
    n_checks++;
    if (intr_channel !== 32'd0 || f_intr_channel !== 32'd5 || f_RDY_ifc_enq !== 4'b1111
        || rdy_msz !== 1'b1 || rdy_ne !== 1'b1 || rdy_is !== 1'b1 || rdy_ic !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_consts: got ch=%h fch=%h frdy=%b rdys=%b%b%b%b, want ch=0 fch=5 frdy=1111 rdys=1111",
               intr_channel, f_intr_channel, f_RDY_ifc_enq, rdy_msz, rdy_ne, rdy_is, rdy_ic);
    end
    // Start a message, then pull reset while it is in flight
    ifc_enq_v[31:0] = 32'h1234_5678;
    EN_ifc_enq = 4'b0011;
    step();
    EN_ifc_enq = 4'b0000;
    steps(2);
    n_checks++;
    if (ind_notEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_msg: got ne=%b, want ne=1", ind_notEmpty);
    end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (ind_notEmpty !== 1'b0 || RDY_ifc_enq !== 4'b1111 || intr_status !== 1'b0
        || ind_first !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: got ne=%b rdy=%b intr=%b first=%h, want ne=0 rdy=1111 intr=0 first=0",
               ind_notEmpty, RDY_ifc_enq, intr_status, ind_first);
    end
    step();
    RST_N = 1'b1;
    steps(6);
    n_checks++;
    if (ind_notEmpty !== 1'b0 || RDY_ifc_enq !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_discard: got ne=%b rdy=%b, want ne=0 rdy=1111", ind_notEmpty, RDY_ifc_enq);
    end
  endtask

  task automatic test_single();
    ifc_enq_v[31:0] = 32'hCAFE_0001;
    EN_ifc_enq = 4'b0001;
    step();
    EN_ifc_enq = 4'b0000;
    n_checks++;
    if (RDY_ifc_enq !== 4'b1110) begin
      n_fail++;
      $display("FAIL single_busy: got rdy=%b, want 1110", RDY_ifc_enq);
    end
    step();
    n_checks++;
    if (ind_notEmpty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: got ne=%b at t+2, want 0", ind_notEmpty);
    end
    step();
    n_checks++;
    if (ind_notEmpty !== 1'b1 || ind_first !== 32'h0000_0002 || rdy_first !== 1'b1
        || rdy_deq !== 1'b1) begin
      n_fail++;
      $display("FAIL single_header: got ne=%b first=%h rdyf=%b rdyd=%b, want ne=1 first=00000002 rdyf=1 rdyd=1",
               ind_notEmpty, ind_first, rdy_first, rdy_deq);
    end
    step();
    EN_ind_deq = 1'b1;
    step();
    n_checks++;
    if (ind_first !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL single_payload: got first=%h, want cafe0001", ind_first);
    end
    step();
    EN_ind_deq = 1'b0;
    n_checks++;
    if (ind_notEmpty !== 1'b0 || RDY_ifc_enq !== 4'b1111 || rdy_deq !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got ne=%b rdy=%b rdyd=%b, want ne=0 rdy=1111 rdyd=0",
               ind_notEmpty, RDY_ifc_enq, rdy_deq);
    end
  endtask

  task automatic test_ignore();
    EN_ind_deq = 1'b1;
    step();
    EN_ind_deq = 1'b0;
    n_checks++;
    if (ind_notEmpty !== 1'b0) begin
      n_fail++;
      $display("FAIL deq_empty: got ne=%b, want 0", ind_notEmpty);
    end
    ifc_enq_v[(2*MW)*32 +: 32] = 32'h1111_2222;
    EN_ifc_enq = 4'b0100;
    step();
    ifc_enq_v[(2*MW)*32 +: 32] = 32'h3333_4444;
    step();
    EN_ifc_enq = 4'b0000;
    steps(6);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] want;
      want = (k == 0) ? 32'h0002_0002 : 32'h1111_2222;
      n_checks++;
      if (ind_notEmpty !== 1'b1 || ind_first !== want) begin
        n_fail++;
        $display("FAIL enq_not_ready[%0d]: got ne=%b first=%h, want ne=1 first=%h",
                 k, ind_notEmpty, ind_first, want);
      end
      EN_ind_deq = 1'b1;
      step();
      EN_ind_deq = 1'b0;
    end
    n_checks++;
    if (ind_notEmpty !== 1'b0) begin
      n_fail++;
      $display("FAIL enq_not_ready_extra: got ne=%b, want 0", ind_notEmpty);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_a [6];
    logic [31:0] exp_c [4];
    exp_a = '{32'h0000_0002, 32'hB000_0000, 32'h0001_0002, 32'hB000_0001,
              32'h0002_0002, 32'hB000_0002};
    exp_c = '{32'h0002_0002, 32'hC000_0002, 32'h0000_0002, 32'hC000_0000};
    for (int m = 0; m < 3; m++) ifc_enq_v[(m*MW)*32 +: 32] = 32'hB000_0000 + m;
    EN_ifc_enq = 4'b0111;
    step();
    EN_ifc_enq = 4'b0000;
    steps(15);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (ind_notEmpty !== 1'b1 || ind_first !== exp_a[k]) begin
        n_fail++;
        $display("FAIL rr_order_a[%0d]: got ne=%b first=%h, want ne=1 first=%h",
                 k, ind_notEmpty, ind_first, exp_a[k]);
      end
      EN_ind_deq = 1'b1;
      step();
      EN_ind_deq = 1'b0;
    end
    // Serve method 1 alone so the pointer sits at 1
    ifc_enq_v[(1*MW)*32 +: 32] = 32'hC000_0001;
    EN_ifc_enq = 4'b0010;
    step();
    EN_ifc_enq = 4'b0000;
    steps(8);
    EN_ind_deq = 1'b1;
    steps(2);
    EN_ind_deq = 1'b0;
    steps(2);
    ifc_enq_v[31:0]            = 32'hC000_0000;
    ifc_enq_v[(2*MW)*32 +: 32] = 32'hC000_0002;
    EN_ifc_enq = 4'b0101;
    step();
    EN_ifc_enq = 4'b0000;
    steps(12);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ind_notEmpty !== 1'b1 || ind_first !== exp_c[k]) begin
        n_fail++;
        $display("FAIL rr_order_c[%0d]: got ne=%b first=%h, want ne=1 first=%h",
                 k, ind_notEmpty, ind_first, exp_c[k]);
      end
      EN_ind_deq = 1'b1;
      step();
      EN_ind_deq = 1'b0;
    end
    n_checks++;
    if (ind_notEmpty !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got ne=%b, want 0", ind_notEmpty);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_f [20];
    for (int m = 0; m < NM; m++) begin
      exp_f[m*5] = {16'(m), 16'd5};
      for (int w = 0; w < MW; w++) begin
        f_ifc_enq_v[(m*MW+w)*32 +: 32] = {16'hF000, 8'(m), 8'(w)};
        exp_f[m*5+1+w] = {16'hF000, 8'(m), 8'(w)};
      end
    end
    f_EN_ifc_enq = 4'b1111;
    step();
    f_EN_ifc_enq = 4'b0000;
    steps(40);
    n_checks++;
    if (f_ind_notEmpty !== 1'b1 || f_RDY_ifc_enq !== 4'b0111 || f_ind_first !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL full_stall: got ne=%b rdy=%b first=%h, want ne=1 rdy=0111 first=00000005",
               f_ind_notEmpty, f_RDY_ifc_enq, f_ind_first);
    end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (f_ind_notEmpty !== 1'b1 || f_ind_first !== exp_f[k]) begin
        n_fail++;
        $display("FAIL full_order[%0d]: got ne=%b first=%h, want ne=1 first=%h",
                 k, f_ind_notEmpty, f_ind_first, exp_f[k]);
      end
      f_EN_ind_deq = 1'b1;
      step();
      f_EN_ind_deq = 1'b0;
      // Method 3 needs exactly four freed slots to finish its payload
      if (k < 4) begin
        steps(3);
        n_checks++;
        if (f_RDY_ifc_enq[3] !== (k == 3)) begin
          n_fail++;
          $display("FAIL full_capacity[%0d]: got rdy3=%b, want %b", k, f_RDY_ifc_enq[3], (k == 3));
        end
      end
    end
    n_checks++;
    if (f_ind_notEmpty !== 1'b0 || f_RDY_ifc_enq !== 4'b1111) begin
      n_fail++;
      $display("FAIL full_drain: got ne=%b rdy=%b, want ne=0 rdy=1111", f_ind_notEmpty, f_RDY_ifc_enq);
    end
  endtask

  task automatic test_msgsize();
    msz_num   = 16'd1;
    f_msz_num = 16'd3;
    #1;
    n_checks++;
    if (msz !== 16'd32 || f_msz !== 16'd128) begin
      n_fail++;
      $display("FAIL msgsize_valid: got %0d/%0d, want 32/128", msz, f_msz);
    end
    msz_num   = 16'd99;
    f_msz_num = 16'd4;
    #1;
    n_checks++;
    if (msz !== 16'd0 || f_msz !== 16'd0) begin
      n_fail++;
      $display("FAIL msgsize_range: got %0d/%0d, want 0/0", msz, f_msz);
    end
  endtask

  task automatic test_intr();
    ifc_enq_v[(3*MW)*32 +: 32] = 32'h0BAD_F00D;
    EN_ifc_enq = 4'b1000;
    step();
    EN_ifc_enq = 4'b0000;
    steps(6);
`ifdef PORTAL_INTR_MASK_EN
    intr_enable = 1'b0;
    #1;
    n_checks++;
    if (intr_status !== 1'b0 || ind_notEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL intr_masked: got intr=%b ne=%b, want intr=0 ne=1", intr_status, ind_notEmpty);
    end
    intr_enable = 1'b1;
    #1;
`endif
    n_checks++;
    if (intr_status !== 1'b1 || ind_first !== 32'h0003_0002) begin
      n_fail++;
      $display("FAIL intr_pending: got intr=%b first=%h, want intr=1 first=00030002",
               intr_status, ind_first);
    end
    EN_ind_deq = 1'b1;
    step();
    n_checks++;
    if (ind_first !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL intr_payload: got first=%h, want 0badf00d", ind_first);
    end
    step();
    EN_ind_deq = 1'b0;
    n_checks++;
    if (intr_status !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_clear: got intr=%b, want 0", intr_status);
    end
  endtask

  initial begin
    RST_N        = 1'b0;
    ifc_enq_v    = '0;
    f_ifc_enq_v  = '0;
    EN_ifc_enq   = '0;
    f_EN_ifc_enq = '0;
    EN_ind_deq   = 1'b0;
    f_EN_ind_deq = 1'b0;
    msz_num      = 16'd0;
    f_msz_num    = 16'd0;
`ifdef PORTAL_INTR_MASK_EN
    intr_enable   = 1'b1;
    f_intr_enable = 1'b1;
`endif
    test_reset();
    test_single();
    test_ignore();
    test_round_robin();
    test_full();
    test_msgsize();
    test_intr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
